// File: rtl/mdu_iter_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
// The issuer is the master; the unit is the slave.
interface mdu_iter_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             req;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, req, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, req, cancel,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
// Multiplies retire after a fixed latency; divides resolve one restoring quotient bit per cycle.
module mdu_iter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 5
) (
    input  logic      clk,
    input  logic      reset,
    mdu_iter_if.slave bus
);
    localparam int unsigned CntMax = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;
    localparam logic [2:0] OpMadd  = 3'd6;
    localparam logic [2:0] OpMsub  = 3'd7;

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDsetup,
        StDiter,
        StDfix
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic [2:0]         op_q, op_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;

    logic               accept;
    logic               is_move;
    logic               mul_signed;
    logic               div_signed;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod_new;
    logic [2*WIDTH-1:0] hilo, mul_res;
    logic [WIDTH:0]     shifted, trial;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign accept  = bus.start && !bus.req && !bus.cancel && (state_q == StIdle);
    assign is_move = (bus.op == OpMthi) || (bus.op == OpMtlo);

    // Combinational so the issuing cycle itself already stalls dependent instructions.
    assign bus.busy = (state_q != StIdle) || (bus.start && !bus.req && !bus.cancel && !is_move);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Extending both operands to 2*WIDTH makes the truncated product right for either signedness.
    assign mul_signed = (bus.op != OpMultu);
    assign ext_a    = mul_signed ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
    assign ext_b    = mul_signed ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
    assign prod_new = ext_a * ext_b;

    assign hilo = {hi_q, lo_q};

    always_comb begin
        unique case (op_q)
            OpMadd:  mul_res = hilo + prod_q;
            OpMsub:  mul_res = hilo - prod_q;
            default: mul_res = prod_q;
        endcase
    end

    // One restoring step: shift the next dividend bit in, keep the trial only if it did not borrow.
    assign div_signed = (op_q == OpDiv);
    assign shifted    = {rem_q, quo_q[WIDTH-1]};
    assign trial      = shifted - {1'b0, dvs_q};
    assign quo_fix    = qneg_q ? -quo_q : quo_q;
    assign rem_fix    = rneg_q ? -rem_q : rem_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        op_d    = op_q;
        prod_d  = prod_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;

        if (bus.cancel && (state_q != StIdle)) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_d = bus.op;
                        unique case (bus.op)
                            OpMthi: hi_d = bus.a;
                            OpMtlo: lo_d = bus.a;
                            OpDiv, OpDivu: begin
                                quo_d   = bus.a;
                                dvs_d   = bus.b;
                                rem_d   = '0;
                                state_d = StDsetup;
                            end
                            default: begin
                                prod_d  = prod_new;
                                cnt_d   = CntW'(MUL_LAT - 1);
                                state_d = StMul;
                            end
                        endcase
                    end
                end
                StMul: begin
                    if (cnt_q == '0) begin
                        {hi_d, lo_d} = mul_res;
                        done_d       = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                StDsetup: begin
                    qneg_d  = div_signed && (quo_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                    rneg_d  = div_signed && quo_q[WIDTH-1];
                    quo_d   = (div_signed && quo_q[WIDTH-1]) ? -quo_q : quo_q;
                    dvs_d   = (div_signed && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
                    rem_d   = '0;
                    cnt_d   = CntW'(WIDTH - 1);
                    state_d = StDiter;
                end
                StDiter: begin
                    rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                    if (cnt_q == '0) begin
                        state_d = StDfix;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                StDfix: begin
                    // A zero divisor still spends the full latency but leaves HI/LO alone.
                    if (dvs_q != '0) begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            op_q    <= '0;
            prod_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            op_q    <= op_d;
            prod_q  <= prod_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end
endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised multiply/divide unit for the execute stage, successor to the fixed-latency 32-bit MDU. Owns the HI/LO register pair and executes signed/unsigned multiply, multiply-accumulate/subtract, and iterative restoring divide, plus the HI/LO move-to writes. Every operation is gated by the pipeline's exception request. In-flight operations can be cancelled, leaving HI/LO untouched.

## Interface
- WIDTH, 32: operand and HI/LO width (≥ 4, even)
- MUL_LAT, 5: multiply busy cycles (≥ 1)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  operation valid this cycle (E stage)
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB
- a  in  WIDTH  rs operand (dividend / multiplicand / move-to source)
- b  in  WIDTH  rt operand (divisor / multiplier)
- req  in  1  exception/flush request; blocks acceptance this cycle
- cancel  in  1  abort in-flight operation
- busy  out  1  unit occupied; issuer stalls mf*/mt*/md ops
- done  out  1  one-cycle pulse: HI/LO updated by md op this cycle edge
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- Accept condition: start && !req && !cancel && state==IDLE.
- MTHI/MTLO on accept: hi/lo <= a at that edge. No busy, no done.
- MULT/MULTU/MADD/MSUB on accept:
  - Latch the 2·WIDTH product (MADD/MSUB signed).
  - Enter MUL and load the counter with MUL_LAT-1.
  - On completion: MULT/MULTU write {hi,lo} = product; MADD writes {hi,lo} + product; MSUB writes {hi,lo} − product; all modulo 2^(2·WIDTH).
- DIV/DIVU on accept: DSETUP, then DITER, then DFIX.
  - DSETUP (1 cycle): latch |a| and |b| (raw values for DIVU), record signs.
  - DITER (WIDTH cycles): one restoring quotient bit per cycle, MSB first.
  - DFIX (1 cycle): apply signs. Quotient is negative iff the signs differ. Remainder takes the dividend's sign. Write lo = quotient, hi = remainder.
- Divide by zero: full latency, hi/lo unchanged, done still pulses.
- Signed overflow, DIV with a = MIN and b = −1: lo = MIN, hi = 0.
- States: IDLE, MUL, DSETUP, DITER, DFIX. Terminal states return to IDLE and assert done.
- Ignored inputs:
  - start while state≠IDLE, including mt*: ignored, no side effect.
  - req: ignored once an operation is in flight.
- cancel while state≠IDLE: next edge → IDLE, counter cleared, hi/lo unchanged, no done.
- cancel in the completion cycle: cancel wins, no write.
- reset: state IDLE, hi = lo = 0, busy = 0, done = 0, counter and datapath regs cleared. Reset mid-operation discards the operation.

## Timing
- Accept at edge T means start is high in cycle T.
- busy = (state≠IDLE) || (start && !req && !cancel && op∉{4,5}). Combinational, so the accept cycle itself stalls the pipeline.
- Multiply:
  - busy high in cycles T … T+MUL_LAT.
  - done and the new hi/lo are visible in cycle T+MUL_LAT+1.
  - busy is low in that same cycle, so back-to-back issue is possible there.
- Divide:
  - busy high in cycles T … T+WIDTH+2 (T+34 for WIDTH=32).
  - Result is visible in cycle T+WIDTH+3.
- done is registered and high exactly one cycle, coincident with the first cycle the new hi/lo are visible.
- mt* writes are visible in cycle T+1.

## Test plan
- Reset, then MULT a=0xFFFFFFFE (−2), b=3 → in cycle T+6, hi=0xFFFFFFFF, lo=0xFFFFFFFA, done=1 for one cycle; busy high in cycles T…T+5.
- MTHI 0, MTLO 10, then MADD a=4, b=5 → lo=30, hi=0. Follow with MSUB a=1, b=31 → hi=0xFFFFFFFF, lo=0xFFFFFFFF.
- DIV a=−7, b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1) at T+35. DIVU a=7, b=2 → lo=3, hi=1.
- Divide by zero and MIN/−1:
  - With hi=0x11, lo=0x22, DIVU b=0 → hi/lo unchanged after 34 busy cycles, done pulses.
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Gating:
  - start with req=1 → no state change, busy low next cycle.
  - DIV accepted, cancel at T+10 → busy low in T+11, hi/lo unchanged, no done.
  - Reset at T+5 mid-MULT → hi=lo=0.
- Parameter sweep: WIDTH=8, MUL_LAT=1, random signed/unsigned operands checked against a reference model (div by zero excluded). Divide latency is 11 cycles.
